// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared state encoding and constants for the pipeline hazard controller.
package pipeline_pkg;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam int LAT_W = 4;
endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: hazard inputs from the datapath and pipeline control outputs.
interface pipeline_hazard_controller_if import pipeline_pkg::*; #(parameter int CNT_W = 16);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic id_uses_rt;
  logic ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic ex_branch_taken;
  logic mem_access;
  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_bubble;
  logic pipe_hold;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, mem_access,
    input pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, stall_cycles, flush_count
  );
  modport slave (
    input id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, mem_access,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, stall_cycles, flush_count
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: counter that clears on reset and sticks at all-ones.
module sat_counter #(parameter int W = 16) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: Mealy stall/flush/freeze control for a 5-stage pipeline.
module pipeline_hazard_controller import pipeline_pkg::*; #(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_controller_if.slave bus
);
  state_t state, state_nx;
  logic [LAT_W-1:0] wait_cnt, wait_nx;
  logic hold, load_use, flush, stall;
  always_comb begin
    hold = (state == MEM_WAIT && wait_cnt != '0) ||
           (state == RUN && bus.mem_access && MEM_LATENCY > 1);
    load_use = bus.ex_mem_read && bus.ex_rt != REG_ZERO &&
               (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
    flush = !hold && bus.ex_branch_taken;
    stall = !hold && !flush && load_use;
    state_nx = state == RUN ? (hold ? MEM_WAIT : RUN) : (wait_cnt != '0 ? MEM_WAIT : RUN);
    wait_nx = state == RUN ? (hold ? LAT_W'(MEM_LATENCY - 2) : wait_cnt)
                           : (wait_cnt != '0 ? wait_cnt - 1'b1 : wait_cnt);
  end
  // Reset forces a safe bubble-only pattern while it is held low
  assign bus.pc_write     = reset && !hold && !stall;
  assign bus.if_id_write  = reset && !hold && !stall;
  assign bus.if_id_flush  = reset && flush;
  assign bus.id_ex_bubble = !reset || flush || stall;
  assign bus.pipe_hold    = reset && hold;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RUN;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      wait_cnt <= wait_nx;
    end
  sat_counter #(.W(CNT_W)) u_stall (.clk(clk), .reset(reset), .inc(!bus.pc_write), .count(bus.stall_cycles));
  sat_counter #(.W(CNT_W)) u_flush (.clk(clk), .reset(reset), .inc(bus.if_id_flush), .count(bus.flush_count));
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed checks across several latency and counter-width configurations.
`define IDLE(b) b.id_rs = 0; b.id_rt = 0; b.id_uses_rt = 0; b.ex_mem_read = 0; b.ex_rt = 0; b.ex_branch_taken = 0; b.mem_access = 0;
module tb_pipeline_hazard_controller;
  logic clk = 0;
  logic reset;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  pipeline_hazard_controller_if b1 ();
  pipeline_hazard_controller_if b4 ();
  pipeline_hazard_controller_if b3 ();
  pipeline_hazard_controller_if b8 ();
  pipeline_hazard_controller_if #(.CNT_W(2)) bs ();
  pipeline_hazard_controller #(.MEM_LATENCY(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  pipeline_hazard_controller #(.MEM_LATENCY(4)) u4 (.clk(clk), .reset(reset), .bus(b4));
  pipeline_hazard_controller #(.MEM_LATENCY(3)) u3 (.clk(clk), .reset(reset), .bus(b3));
  pipeline_hazard_controller #(.MEM_LATENCY(8)) u8 (.clk(clk), .reset(reset), .bus(b8));
  pipeline_hazard_controller #(.MEM_LATENCY(1), .CNT_W(2)) us (.clk(clk), .reset(reset), .bus(bs));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 0;
    `IDLE(b1) `IDLE(b4) `IDLE(b3) `IDLE(b8) `IDLE(bs)
    #1;
    chk("rst_pc_write", 32'(b1.pc_write), 0);
    chk("rst_if_id_write", 32'(b1.if_id_write), 0);
    chk("rst_bubble", 32'(b1.id_ex_bubble), 1);
    chk("rst_flush", 32'(b1.if_id_flush), 0);
    chk("rst_hold", 32'(b4.pipe_hold), 0);
    chk("rst_stall_cnt", 32'(b1.stall_cycles), 0);
    chk("rst_flush_cnt", 32'(b1.flush_count), 0);
    #10 reset = 1;
    #1;
    chk("dflt_pc_write", 32'(b1.pc_write), 1);
    chk("dflt_bubble", 32'(b1.id_ex_bubble), 0);
    // load-use on rs
    cyc();
    b1.ex_mem_read = 1; b1.ex_rt = 8; b1.id_rs = 8;
    #1;
    chk("lu_pc_write", 32'(b1.pc_write), 0);
    chk("lu_if_id_write", 32'(b1.if_id_write), 0);
    chk("lu_bubble", 32'(b1.id_ex_bubble), 1);
    chk("lu_flush", 32'(b1.if_id_flush), 0);
    cyc();
    b1.ex_mem_read = 0;
    #1;
    chk("lu_stall_cnt", 32'(b1.stall_cycles), 1);
    chk("lu_after_pc_write", 32'(b1.pc_write), 1);
    chk("lu_after_bubble", 32'(b1.id_ex_bubble), 0);
    // register zero and unused rt never stall
    b1.ex_mem_read = 1; b1.ex_rt = 0; b1.id_rs = 0;
    #1;
    chk("r0_pc_write", 32'(b1.pc_write), 1);
    b1.ex_rt = 9; b1.id_rt = 9; b1.id_rs = 3; b1.id_uses_rt = 0;
    #1;
    chk("rt_unused_pc_write", 32'(b1.pc_write), 1);
    b1.id_uses_rt = 1;
    #1;
    chk("rt_used_pc_write", 32'(b1.pc_write), 0);
    b1.id_uses_rt = 0; b1.ex_mem_read = 0;
    // taken branch overrides load-use
    cyc();
    b1.ex_branch_taken = 1; b1.ex_mem_read = 1; b1.ex_rt = 8; b1.id_rs = 8;
    #1;
    chk("br_flush", 32'(b1.if_id_flush), 1);
    chk("br_bubble", 32'(b1.id_ex_bubble), 1);
    chk("br_pc_write", 32'(b1.pc_write), 1);
    chk("br_if_id_write", 32'(b1.if_id_write), 1);
    cyc();
    b1.ex_branch_taken = 0; b1.ex_mem_read = 0;
    #1;
    chk("br_flush_cnt", 32'(b1.flush_count), 1);
    chk("br_stall_cnt", 32'(b1.stall_cycles), 1);
    chk("br_after_flush", 32'(b1.if_id_flush), 0);
    // latency-4 freeze: three held cycles, release on the fourth
    b4.mem_access = 1;
    #1;
    chk("mf_c1_hold", 32'(b4.pipe_hold), 1);
    chk("mf_c1_pc_write", 32'(b4.pc_write), 0);
    chk("mf_c1_bubble", 32'(b4.id_ex_bubble), 0);
    cyc();
    chk("mf_c2_hold", 32'(b4.pipe_hold), 1);
    cyc();
    chk("mf_c3_hold", 32'(b4.pipe_hold), 1);
    chk("mf_c3_if_id_write", 32'(b4.if_id_write), 0);
    cyc();
    chk("mf_c4_hold", 32'(b4.pipe_hold), 0);
    chk("mf_c4_pc_write", 32'(b4.pc_write), 1);
    chk("mf_c4_stall_cnt", 32'(b4.stall_cycles), 3);
    b4.mem_access = 0;
    cyc();
    chk("mf_c5_pc_write", 32'(b4.pc_write), 1);
    chk("mf_c5_stall_cnt", 32'(b4.stall_cycles), 3);
    // latency-3 hold defers a taken branch to the release cycle
    b3.mem_access = 1; b3.ex_branch_taken = 1;
    #1;
    chk("hb_c1_hold", 32'(b3.pipe_hold), 1);
    chk("hb_c1_flush", 32'(b3.if_id_flush), 0);
    cyc();
    chk("hb_c2_hold", 32'(b3.pipe_hold), 1);
    chk("hb_c2_flush", 32'(b3.if_id_flush), 0);
    cyc();
    chk("hb_c3_hold", 32'(b3.pipe_hold), 0);
    chk("hb_c3_flush", 32'(b3.if_id_flush), 1);
    chk("hb_c3_pc_write", 32'(b3.pc_write), 1);
    b3.mem_access = 0;
    cyc();
    b3.ex_branch_taken = 0;
    #1;
    chk("hb_flush_cnt", 32'(b3.flush_count), 1);
    chk("hb_stall_cnt", 32'(b3.stall_cycles), 2);
    // 2-bit counters saturate at 3
    bs.ex_mem_read = 1; bs.ex_rt = 8; bs.id_rs = 8;
    repeat (4) cyc();
    chk("sat_stall_cnt", 32'(bs.stall_cycles), 3);
    bs.ex_mem_read = 0; bs.ex_branch_taken = 1;
    repeat (4) cyc();
    chk("sat_flush_cnt", 32'(bs.flush_count), 3);
    chk("sat_stall_hold", 32'(bs.stall_cycles), 3);
    bs.ex_branch_taken = 0;
    // reset asserted in the middle of a latency-8 wait
    cyc();
    b8.mem_access = 1;
    #1;
    chk("rw_c1_hold", 32'(b8.pipe_hold), 1);
    cyc();
    chk("rw_c2_hold", 32'(b8.pipe_hold), 1);
    cyc();
    chk("rw_pre_stall_cnt", 32'(b8.stall_cycles), 2);
    reset = 0;
    #1;
    chk("rw_rst_bubble", 32'(b8.id_ex_bubble), 1);
    chk("rw_rst_hold", 32'(b8.pipe_hold), 0);
    chk("rw_rst_pc_write", 32'(b8.pc_write), 0);
    chk("rw_rst_stall_cnt", 32'(b8.stall_cycles), 0);
    chk("rw_rst_flush_cnt", 32'(b1.flush_count), 0);
    b8.mem_access = 0;
    cyc();
    reset = 1;
    #1;
    chk("rw_rel_pc_write", 32'(b8.pc_write), 1);
    chk("rw_rel_hold", 32'(b8.pipe_hold), 0);
    chk("rw_rel_bubble", 32'(b8.id_ex_bubble), 0);
    cyc();
    chk("rw_run_pc_write", 32'(b8.pc_write), 1);
    chk("rw_run_stall_cnt", 32'(b8.stall_cycles), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Detects load-use hazards and inserts one bubble into ID/EX.
- Flushes wrong-path instructions on a taken branch.
- Freezes the whole pipeline while a multi-cycle data-memory access completes.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- MEM_LATENCY, 1, data-memory access latency in cycles (1 = single cycle, no freeze). Legal range 1..16.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-low reset.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rt  input  1  the ID instruction reads rt as a source.
- ex_mem_read  input  1  ID/EX mem_read (the instruction now in EX is a load).
- ex_rt  input  5  ID/EX rt (the load's destination register).
- ex_branch_taken  input  1  the branch in EX resolved as taken.
- mem_access  input  1  EX/MEM mem_read or mem_write (a memory op is in MEM).
- pc_write  output  1  PC load enable.
- if_id_write  output  1  IF/ID load enable.
- if_id_flush  output  1  IF/ID clears to NOP on the next clock edge.
- id_ex_bubble  output  1  zero all ID/EX control inputs (inject a bubble).
- pipe_hold  output  1  hold ID/EX, EX/MEM and MEM/WB.
- stall_cycles  output  CNT_W  count of cycles with pc_write=0.
- flush_count  output  CNT_W  count of branch flushes.

Behaviour:
- State machine states are RUN and MEM_WAIT. A wait counter wait_cnt is 4 bits.
- Reset (reset=0, asynchronous):
  - state=RUN, wait_cnt=0, stall_cycles=0, flush_count=0.
  - While reset is low, the combinational outputs are pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1, pipe_hold=0.
- Control outputs are combinational from the current state and inputs (Mealy), so they act in the same cycle. Counters and state are registered.
- Default outputs (no event): pc_write=1, if_id_write=1, all other controls 0.
- Hold condition, highest priority. Hold is active when either:
  - state=MEM_WAIT and wait_cnt!=0, or
  - state=RUN, mem_access=1 and MEM_LATENCY>1.
- Hold outputs: pc_write=0, if_id_write=0, pipe_hold=1, if_id_flush=0, id_ex_bubble=0.
- Hold sequencing:
  - In RUN, when hold starts, load wait_cnt=MEM_LATENCY-2 and go to MEM_WAIT.
  - In MEM_WAIT with wait_cnt!=0, decrement wait_cnt.
  - In MEM_WAIT with wait_cnt==0, release: outputs take normal (non-hold) values, go to RUN. Branch and load-use are evaluated in this cycle.
  - Total frozen cycles per access = MEM_LATENCY-1.
  - A new hold cannot start in the release cycle; the memory op advances on that edge.
- Branch flush, second priority (ex_branch_taken=1 and no hold):
  - if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1.
  - A flush deferred by hold fires in the release cycle.
- Load-use, third priority (no hold, no flush). The hazard is:
  - ex_mem_read=1, ex_rt!=0, and
  - either ex_rt==id_rs, or id_uses_rt=1 and ex_rt==id_rt.
- Load-use outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
- The bubble clears ex_mem_read on the next cycle, so a load-use stall lasts exactly one cycle with no extra state.
- A taken branch suppresses load-use, because the ID instruction is discarded.
- stall_cycles increments on every non-reset cycle with pc_write=0 and saturates at all-ones.
- flush_count increments on every cycle with if_id_flush=1 and saturates at all-ones.
- Reset asserted mid-MEM_WAIT aborts the wait immediately. The counters clear.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - the state encoding (RUN=1'b0, MEM_WAIT=1'b1);
  - the register-zero constant REG_ZERO=5'd0;
  - the memory-latency width constant.
- Natural sub-module: sat_counter (parameter W, inputs clk, reset, clear-on-reset, inc; output count, saturating). Instantiated twice.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5'd8, id_rs=5'd8, MEM_LATENCY=1 → one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cycles=1; next cycle (ex_mem_read=0) defaults.
- Register-zero immunity: ex_mem_read=1, ex_rt=0, id_rs=0 → no stall. Also ex_rt=5'd9, id_rt=5'd9, id_uses_rt=0 → no stall.
- Branch plus hazard: ex_branch_taken=1 with the load-use condition true → if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count=1, stall_cycles unchanged.
- Memory freeze: MEM_LATENCY=4, mem_access=1 for one instruction → pipe_hold=1 and pc_write=0 for exactly 3 cycles, released on the 4th; stall_cycles=3.
- Hold beats branch: MEM_LATENCY=3, mem_access=1 and ex_branch_taken=1 together → 2 hold cycles with if_id_flush=0, then if_id_flush=1 in the release cycle; flush_count=1.
- Reset mid-wait: MEM_LATENCY=8, drop reset after 2 hold cycles → state RUN, counters 0, id_ex_bubble=1 while low. After release with mem_access=0 → defaults.
